word_unpack: RTL

WORD_UNPACK -- requirements
Module: word_unpack

---
 rtl/word_unpack_if.sv | 30 +++
 rtl/word_unpack.sv | 161 ++++++++++++++++
 2 files changed

// File: rtl/word_unpack_if.sv
// rtl/word_unpack_if.sv - upstream word / downstream pixel handshake bundle for word_unpack
`ifndef DSIZE
`define DSIZE 36
`endif
`ifndef MAX_FRM_COL
`define MAX_FRM_COL 16
`endif

interface word_unpack_if;
  logic               us_vld;
  logic               us_rdy;
  logic [`DSIZE-1:0]  us_data;
  logic               pix_vld;
  logic               pix_rdy;
  logic [7:0]         pix_data;
  logic               pix_sof;
  logic               pix_eol;
  logic               pix_eof;
  logic               frame_err;

  modport master (
    output us_vld, us_data, pix_rdy,
    input  us_rdy, pix_vld, pix_data, pix_sof, pix_eol, pix_eof, frame_err
  );

  modport slave (
    input  us_vld, us_data, pix_rdy,
    output us_rdy, pix_vld, pix_data, pix_sof, pix_eol, pix_eof, frame_err
  );
endinterface

// File: rtl/word_unpack.sv
// rtl/word_unpack.sv - 32-bit word to 8-bit pixel unpacker with SOF sync; WORD_UNPACK_FRAME_CHECK_EN adds frame_err
module word_unpack #(
  parameter bit MSB_FIRST = 1'b0
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          en,
  word_unpack_if.slave  bus
);

  localparam logic [9:0] COL_LAST = 10'(`MAX_FRM_COL - 1);

  typedef enum logic {
    SYNC = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t      state_q, state_d;
  logic        full_q, full_d;
  logic [33:0] word_q, word_d;
  logic [1:0]  idx_q, idx_d;
  logic [9:0]  col_q, col_d;

  logic        last_byte;
  logic        pix_vld;
  logic        pix_fire;
  logic        us_rdy;
  logic        us_fire;
  logic        us_sof;
  logic        eof_fire;
  logic        load_word;
  logic [1:0]  sel;
  logic [7:0]  cur_byte;
  logic        unused_hi;

  // bits above the EOF flag carry nothing for this stage
  assign unused_hi = ^bus.us_data[`DSIZE-1:34];

  // handshake qualifiers shared by the FSM and the datapath
  always_comb begin
    last_byte = (idx_q == 2'd3);
    pix_vld   = en & full_q & (state_q == RUN);
    pix_fire  = pix_vld & bus.pix_rdy;
    us_rdy    = rst_n & en & (~full_q | (pix_fire & last_byte));
    us_fire   = bus.us_vld & us_rdy;
    us_sof    = bus.us_data[32];
    eof_fire  = pix_fire & last_byte & word_q[33];
    // a SOF word always loads; other words only continue an open frame
    load_word = us_fire & (us_sof | ((state_q == RUN) & ~eof_fire));
  end

  // state register
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= SYNC;
    end else begin
      state_q <= state_d;
    end
  end

  // next state: SOF wins over the EOF return so back-to-back frames lose nothing
  always_comb begin
    state_d = state_q;
    if (!en) begin
      state_d = SYNC;
    end else if (us_fire & us_sof) begin
      state_d = RUN;
    end else if (eof_fire) begin
      state_d = SYNC;
    end
  end

  // next word register, byte index and column counter
  always_comb begin
    full_d = full_q;
    word_d = word_q;
    idx_d  = idx_q;
    col_d  = col_q;
    if (!en) begin
      full_d = 1'b0;
      idx_d  = 2'd0;
      col_d  = 10'd0;
    end else begin
      if (pix_fire) begin
        idx_d = idx_q + 2'd1;
        if (last_byte) begin
          full_d = 1'b0;
        end
        if ((col_q == COL_LAST) || eof_fire) begin
          col_d = 10'd0;
        end else begin
          col_d = col_q + 10'd1;
        end
      end
      if (load_word) begin
        word_d = bus.us_data[33:0];
        full_d = 1'b1;
        idx_d  = 2'd0;
        if (us_sof) begin
          col_d = 10'd0;
        end
      end
    end
  end

  // datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      word_q <= '0;
      idx_q  <= 2'd0;
      col_q  <= 10'd0;
    end else begin
      full_q <= full_d;
      word_q <= word_d;
      idx_q  <= idx_d;
      col_q  <= col_d;
    end
  end

  // outputs: pixel fields are forced to zero whenever no pixel is offered
  always_comb begin
    sel = MSB_FIRST ? (2'd3 - idx_q) : idx_q;
    case (sel)
      2'd0:    cur_byte = word_q[7:0];
      2'd1:    cur_byte = word_q[15:8];
      2'd2:    cur_byte = word_q[23:16];
      default: cur_byte = word_q[31:24];
    endcase
    bus.us_rdy   = us_rdy;
    bus.pix_vld  = pix_vld;
    bus.pix_data = pix_vld ? cur_byte : 8'h00;
    bus.pix_sof  = pix_vld & word_q[32] & (idx_q == 2'd0);
    bus.pix_eof  = pix_vld & word_q[33] & last_byte;
    bus.pix_eol  = pix_vld & (col_q == COL_LAST);
  end

`ifdef WORD_UNPACK_FRAME_CHECK_EN
  logic err_q, err_d;

  // short/long frame at EOF, or a frame restarted by an unexpected SOF
  always_comb begin
    err_d = en & ((eof_fire & (col_q != COL_LAST)) |
                  (us_fire & us_sof & (state_q == RUN) & ~eof_fire));
  end

  // one-cycle error pulse
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      err_q <= 1'b0;
    end else begin
      err_q <= err_d;
    end
  end

  assign bus.frame_err = err_q;
`else
  assign bus.frame_err = 1'b0;
`endif

endmodule
